// File: rtl/sc_multilane_backg_bank.sv
// -----------------------------------------------------------------------------
// sc_multilane_backg_bank
//
// Bank of LANES independent rotating background registers, DATAWIDTH bits
// each, used for the playfield background / obstacle rows.
//
// Each lane is loaded with a fixed per-level pattern, or with INIT_PATTERN on
// clear. The last lane also ORs in a point mask on load. Once loaded, each lane
// rotates left or right at its own programmable rate. After DATAWIDTH
// rotations, the lane's wrap output pulses for one cycle.
//
// Ports
//   SC_MultiLaneBackgBank_CLOCK_50          : system clock, rising edge
//   SC_MultiLaneBackgBank_RESET_InLow       : synchronous reset, active-low
//   SC_MultiLaneBackgBank_clear_InLow       : load INIT_PATTERN into all lanes
//   SC_MultiLaneBackgBank_load_InLow        : load level patterns into all lanes
//   SC_MultiLaneBackgBank_level_InBUS       : level select used by load
//   SC_MultiLaneBackgBank_overlay_InBUS     : point mask ORed into lane LANES-1 on load
//   SC_MultiLaneBackgBank_shiftenable_InLow : rotation enable, active-low
//   SC_MultiLaneBackgBank_direction_InBUS   : per lane, 1 = rotate left, 0 = right
//   SC_MultiLaneBackgBank_period_InBUS      : per lane P, rotate every P+1 enabled cycles
//   SC_MultiLaneBackgBank_data_OutBUS       : lane l at [(l+1)*DATAWIDTH-1 : l*DATAWIDTH]
//   SC_MultiLaneBackgBank_wrap_OutBUS       : per-lane one-cycle full-rotation pulse
//
// Update priority on each edge: reset > clear > load > rotate > hold.
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module sc_multilane_backg_bank #(
  parameter int DATAWIDTH = 8,
  parameter int LANES     = 4,
  parameter int LEVELS    = 4,
  parameter int TICKW     = 4,
  parameter logic [DATAWIDTH-1:0]               INIT_PATTERN   = '0,
  parameter logic [LANES*LEVELS*DATAWIDTH-1:0]  LEVEL_PATTERNS = '0,
  parameter int LEVELW    = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic                       SC_MultiLaneBackgBank_CLOCK_50,
  input  logic                       SC_MultiLaneBackgBank_RESET_InLow,
  input  logic                       SC_MultiLaneBackgBank_clear_InLow,
  input  logic                       SC_MultiLaneBackgBank_load_InLow,
  input  logic [LEVELW-1:0]          SC_MultiLaneBackgBank_level_InBUS,
  input  logic [DATAWIDTH-1:0]       SC_MultiLaneBackgBank_overlay_InBUS,
  input  logic                       SC_MultiLaneBackgBank_shiftenable_InLow,
  input  logic [LANES-1:0]           SC_MultiLaneBackgBank_direction_InBUS,
  input  logic [LANES*TICKW-1:0]     SC_MultiLaneBackgBank_period_InBUS,
  output logic [LANES*DATAWIDTH-1:0] SC_MultiLaneBackgBank_data_OutBUS,
  output logic [LANES-1:0]           SC_MultiLaneBackgBank_wrap_OutBUS
);

  // Shift counter runs 0..DATAWIDTH-1.
  localparam int SHW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [SHW-1:0] SH_LAST = SHW'(DATAWIDTH - 1);

  // Rotate toward the MSB: bit[W-1] re-enters at bit 0.
  // The form also holds for DATAWIDTH = 1.
  function automatic logic [DATAWIDTH-1:0] rot_left(input logic [DATAWIDTH-1:0] v);
    rot_left = (v << 1) | (v >> (DATAWIDTH - 1));
  endfunction

  // Rotate toward the LSB: bit 0 re-enters at bit[W-1].
  function automatic logic [DATAWIDTH-1:0] rot_right(input logic [DATAWIDTH-1:0] v);
    rot_right = (v >> 1) | (v << (DATAWIDTH - 1));
  endfunction

  // Pattern for lane l at level lvl. A level with no table entry falls back
  // to INIT_PATTERN.
  function automatic logic [DATAWIDTH-1:0] level_pattern(input int l,
                                                         input logic [LEVELW-1:0] lvl);
    if (int'(lvl) < LEVELS) begin
      level_pattern = LEVEL_PATTERNS[(l*LEVELS + int'(lvl))*DATAWIDTH +: DATAWIDTH];
    end else begin
      level_pattern = INIT_PATTERN;
    end
  endfunction

  logic [DATAWIDTH-1:0] lane_r  [LANES];
  logic [TICKW-1:0]     tick_r  [LANES];
  logic [SHW-1:0]       shift_r [LANES];
  logic [LANES-1:0]     wrap_r;

  logic [DATAWIDTH-1:0] lane_s  [LANES];
  logic [TICKW-1:0]     tick_s  [LANES];
  logic [SHW-1:0]       shift_s [LANES];
  logic [LANES-1:0]     wrap_s;
  logic [TICKW-1:0]     period_s[LANES];

  // Per-lane next-state: clear > load > rotate > hold.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_s[l]   = lane_r[l];
      tick_s[l]   = tick_r[l];
      shift_s[l]  = shift_r[l];
      wrap_s[l]   = 1'b0;
      period_s[l] = SC_MultiLaneBackgBank_period_InBUS[l*TICKW +: TICKW];

      if (!SC_MultiLaneBackgBank_clear_InLow) begin
        lane_s[l]  = INIT_PATTERN;
        tick_s[l]  = '0;
        shift_s[l] = '0;
      end else if (!SC_MultiLaneBackgBank_load_InLow) begin
        if (l == LANES - 1) begin
          lane_s[l] = level_pattern(l, SC_MultiLaneBackgBank_level_InBUS)
                    | SC_MultiLaneBackgBank_overlay_InBUS;
        end else begin
          lane_s[l] = level_pattern(l, SC_MultiLaneBackgBank_level_InBUS);
        end
        tick_s[l]  = '0;
        shift_s[l] = '0;
      end else if (!SC_MultiLaneBackgBank_shiftenable_InLow) begin
        if (tick_r[l] == period_s[l]) begin
          if (SC_MultiLaneBackgBank_direction_InBUS[l]) begin
            lane_s[l] = rot_left(lane_r[l]);
          end else begin
            lane_s[l] = rot_right(lane_r[l]);
          end
          tick_s[l] = '0;
          // Rotations are counted regardless of direction.
          if (shift_r[l] == SH_LAST) begin
            shift_s[l] = '0;
            wrap_s[l]  = 1'b1;
          end else begin
            shift_s[l] = shift_r[l] + SHW'(1);
          end
        end else begin
          // A tick above a newly lowered P counts on through overflow.
          tick_s[l] = tick_r[l] + TICKW'(1);
        end
      end else begin
        // Disabled: hold lane and counters. Wrap drops via its default.
        lane_s[l] = lane_r[l];
      end
    end
  end

  // State registers with synchronous active-low reset to all-zero.
  always_ff @(posedge SC_MultiLaneBackgBank_CLOCK_50) begin
    if (!SC_MultiLaneBackgBank_RESET_InLow) begin
      for (int l = 0; l < LANES; l++) begin
        lane_r[l]  <= '0;
        tick_r[l]  <= '0;
        shift_r[l] <= '0;
      end
      wrap_r <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        lane_r[l]  <= lane_s[l];
        tick_r[l]  <= tick_s[l];
        shift_r[l] <= shift_s[l];
      end
      wrap_r <= wrap_s;
    end
  end

  // Flatten the lane registers onto the output bus.
  always_comb begin
    SC_MultiLaneBackgBank_data_OutBUS = '0;
    for (int l = 0; l < LANES; l++) begin
      SC_MultiLaneBackgBank_data_OutBUS[l*DATAWIDTH +: DATAWIDTH] = lane_r[l];
    end
  end

  assign SC_MultiLaneBackgBank_wrap_OutBUS = wrap_r;

endmodule

// File: tb/tb_sc_multilane_backg_bank.sv
// -----------------------------------------------------------------------------
// tb_sc_multilane_backg_bank
//
// Drives two builds of the bank from the same inputs:
//   dut_a : LEVELS = 4
//   dut_b : LEVELS = 3, so level 3 selects the INIT fallback
// Both builds use 2 lanes of 8 bits. Each cycle, both are compared against a
// behavioural model written with integer arithmetic. A directed scenario runs
// first, then a randomized run.
// -----------------------------------------------------------------------------
module tb_sc_multilane_backg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clear_n, load_n, shen_n;
  logic [1:0]  level;
  logic [7:0]  overlay;
  logic [1:0]  dir;
  logic [7:0]  period;
  logic [15:0] data_a, data_b;
  logic [1:0]  wrap_a, wrap_b;

  sc_multilane_backg_bank #(
    .DATAWIDTH(8), .LANES(2), .LEVELS(4), .TICKW(4),
    .INIT_PATTERN(8'h00),
    .LEVEL_PATTERNS(64'h0F07_0301_FFE7_C381)
  ) dut_a (
    .SC_MultiLaneBackgBank_CLOCK_50(clk),
    .SC_MultiLaneBackgBank_RESET_InLow(rst_n),
    .SC_MultiLaneBackgBank_clear_InLow(clear_n),
    .SC_MultiLaneBackgBank_load_InLow(load_n),
    .SC_MultiLaneBackgBank_level_InBUS(level),
    .SC_MultiLaneBackgBank_overlay_InBUS(overlay),
    .SC_MultiLaneBackgBank_shiftenable_InLow(shen_n),
    .SC_MultiLaneBackgBank_direction_InBUS(dir),
    .SC_MultiLaneBackgBank_period_InBUS(period),
    .SC_MultiLaneBackgBank_data_OutBUS(data_a),
    .SC_MultiLaneBackgBank_wrap_OutBUS(wrap_a)
  );

  sc_multilane_backg_bank #(
    .DATAWIDTH(8), .LANES(2), .LEVELS(3), .TICKW(4),
    .INIT_PATTERN(8'h00),
    .LEVEL_PATTERNS(48'h07_0301_E7_C381)
  ) dut_b (
    .SC_MultiLaneBackgBank_CLOCK_50(clk),
    .SC_MultiLaneBackgBank_RESET_InLow(rst_n),
    .SC_MultiLaneBackgBank_clear_InLow(clear_n),
    .SC_MultiLaneBackgBank_load_InLow(load_n),
    .SC_MultiLaneBackgBank_level_InBUS(level),
    .SC_MultiLaneBackgBank_overlay_InBUS(overlay),
    .SC_MultiLaneBackgBank_shiftenable_InLow(shen_n),
    .SC_MultiLaneBackgBank_direction_InBUS(dir),
    .SC_MultiLaneBackgBank_period_InBUS(period),
    .SC_MultiLaneBackgBank_data_OutBUS(data_b),
    .SC_MultiLaneBackgBank_wrap_OutBUS(wrap_b)
  );

  // Reference model state, indexed [build][lane].
  int pat [2][2][4];
  int nlev[2];
  int lane_m[2][2];
  int tick_m[2][2];
  int rots_m[2][2];   // rotations since the last reset/clear/load
  int wrap_m[2][2];

  int n_vec = 0;
  int n_bad = 0;

  // Count one comparison and report it if it does not match.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    int p;
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < 2; l++) begin
        wrap_m[d][l] = 0;
        if (!rst_n) begin
          lane_m[d][l] = 0; tick_m[d][l] = 0; rots_m[d][l] = 0;
        end else if (!clear_n) begin
          lane_m[d][l] = 0; tick_m[d][l] = 0; rots_m[d][l] = 0;
        end else if (!load_n) begin
          lane_m[d][l] = (int'(level) < nlev[d]) ? pat[d][l][level] : 0;
          if (l == 1) lane_m[d][l] = lane_m[d][l] | int'(overlay);
          tick_m[d][l] = 0; rots_m[d][l] = 0;
        end else if (!shen_n) begin
          p = (int'(period) >> (4*l)) & 15;
          if (tick_m[d][l] == p) begin
            if (dir[l]) lane_m[d][l] = ((lane_m[d][l] * 2) | (lane_m[d][l] / 128)) % 256;
            else        lane_m[d][l] = ((lane_m[d][l] / 2) | ((lane_m[d][l] % 2) * 128));
            tick_m[d][l] = 0;
            rots_m[d][l] = rots_m[d][l] + 1;
            if (rots_m[d][l] % 8 == 0) wrap_m[d][l] = 1;
          end else begin
            tick_m[d][l] = (tick_m[d][l] + 1) % 16;
          end
        end
      end
    end
  endtask

  // One clock edge: update the model, then compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("data_a", {16'h0, data_a}, 32'(lane_m[0][1] * 256 + lane_m[0][0]));
    check("wrap_a", {30'h0, wrap_a}, 32'(wrap_m[0][1] * 2 + wrap_m[0][0]));
    check("data_b", {16'h0, data_b}, 32'(lane_m[1][1] * 256 + lane_m[1][0]));
    check("wrap_b", {30'h0, wrap_b}, 32'(wrap_m[1][1] * 2 + wrap_m[1][0]));
  endtask

  logic [15:0] saved;

  initial begin
    pat[0][0] = '{32'h81, 32'hC3, 32'hE7, 32'hFF};
    pat[0][1] = '{32'h01, 32'h03, 32'h07, 32'h0F};
    pat[1][0] = '{32'h81, 32'hC3, 32'hE7, 32'h00};
    pat[1][1] = '{32'h01, 32'h03, 32'h07, 32'h00};
    nlev[0] = 4;
    nlev[1] = 3;
    for (int d = 0; d < 2; d++) begin
      for (int l = 0; l < 2; l++) begin
        lane_m[d][l] = 0; tick_m[d][l] = 0; rots_m[d][l] = 0; wrap_m[d][l] = 0;
      end
    end

    // Reset held for two cycles, then a clear.
    rst_n = 1'b0; clear_n = 1'b1; load_n = 1'b1; shen_n = 1'b1;
    level = 2'd0; overlay = 8'h00; dir = 2'b00; period = 8'h00;
    cycle(); cycle();
    check("reset_data", {16'h0, data_a}, 32'h0000);
    check("reset_wrap", {30'h0, wrap_a}, 32'h0);
    rst_n = 1'b1; clear_n = 1'b0;
    cycle();
    check("clear_data", {16'h0, data_a}, 32'h0000);
    clear_n = 1'b1;

    // Level loads with overlay; level 3 is out of range for dut_b.
    load_n = 1'b0; level = 2'd1; overlay = 8'h80;
    cycle();
    check("load_l1", {16'h0, data_a}, 32'h83C3);
    level = 2'd3;
    cycle();
    check("load_l3", {16'h0, data_a}, 32'h8FFF);
    check("load_l3_init_b", {16'h0, data_b}, 32'h8000);
    level = 2'd1;
    cycle();
    load_n = 1'b1;

    // Full-speed rotation: lane0 rotates left, lane1 rotates right.
    shen_n = 1'b0; dir = 2'b01; period = 8'h00;
    cycle();
    check("rot1", {16'h0, data_a}, 32'hC187);
    for (int i = 0; i < 6; i++) cycle();
    check("wrap_pre", {30'h0, wrap_a}, 32'h0);
    cycle();
    check("rot8", {16'h0, data_a}, 32'h83C3);
    check("wrap8", {30'h0, wrap_a}, 32'h3);
    cycle();
    check("wrap_post", {30'h0, wrap_a}, 32'h0);

    // Mixed rates, then hold with rotation disabled.
    period = 8'h02;
    for (int i = 0; i < 6; i++) cycle();
    saved = data_a;
    shen_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_data", {16'h0, data_a}, {16'h0, saved});
      check("hold_wrap", {30'h0, wrap_a}, 32'h0);
    end

    // Clear and load together mid-rotation: clear wins and counters restart.
    shen_n = 1'b0;
    cycle(); cycle();
    clear_n = 1'b0; load_n = 1'b0;
    cycle();
    check("clr_vs_load", {16'h0, data_a}, 32'h0000);
    clear_n = 1'b1; load_n = 1'b1; period = 8'h00;
    for (int i = 0; i < 9; i++) cycle();

    // Reset beats a simultaneous load during rotation.
    load_n = 1'b0; level = 2'd2;
    cycle();
    load_n = 1'b1;
    cycle(); cycle();
    rst_n = 1'b0; load_n = 1'b0;
    cycle();
    check("rst_vs_load", {16'h0, data_a}, 32'h0000);
    rst_n = 1'b1; load_n = 1'b1;

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      clear_n = ($urandom_range(0, 59) != 0);
      load_n  = ($urandom_range(0, 24) != 0);
      shen_n  = ($urandom_range(0, 4) == 0);
      level   = 2'($urandom_range(0, 3));
      overlay = 8'($urandom);
      if ($urandom_range(0, 9) == 0) dir = 2'($urandom);
      if ($urandom_range(0, 15) == 0) period = 8'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
